// File: rtl/pll_drp_reconfig.sv
// -----------------------------------------------------------------------------
// pll_drp_reconfig
//
// Reconfigures a PLL through its Dynamic Reconfiguration Port. Each entry
// gets a read-modify-write. The PLL is held in reset for the whole sequence
// and released once after the entry marked last. The controller then waits
// for LOCKED. If DRDY or LOCKED does not arrive within its timeout, the
// controller returns to IDLE with a sticky error flag.
//
// Ports
//   i_dclk        DRP clock, rising edge (also clocks the PLL DRP)
//   i_rstn        asynchronous active-low reset
//   i_start       single-cycle request to begin a reconfiguration
//   i_cfg_valid   configuration entry present
//   o_cfg_ready   entry accepted this cycle (high only while waiting for one)
//   i_cfg_addr    DRP register address of the entry
//   i_cfg_mask    1 bits keep the current register value
//   i_cfg_data    new value for bits whose mask bit is 0
//   i_cfg_last    final entry of the sequence
//   o_pll_rst     PLL RST, active high
//   i_locked      PLL LOCKED
//   o_den/o_dwe   DRP enable / write strobe
//   o_daddr/o_di  DRP address / write data
//   i_do/i_drdy   DRP read data / ready
//   o_busy        controller not idle
//   o_done        one-cycle pulse on successful lock
//   o_error       sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module pll_drp_reconfig #(
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        i_dclk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic        i_cfg_valid,
  output logic        o_cfg_ready,
  input  logic [6:0]  i_cfg_addr,
  input  logic [15:0] i_cfg_mask,
  input  logic [15:0] i_cfg_data,
  input  logic        i_cfg_last,
  output logic        o_pll_rst,
  input  logic        i_locked,
  output logic        o_den,
  output logic        o_dwe,
  output logic [6:0]  o_daddr,
  output logic [15:0] o_di,
  input  logic [15:0] i_do,
  input  logic        i_drdy,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  // The single counter serves the hold phase and both timeout waits.
  // It is sized for the largest of the three limits.
  localparam int MAX_A = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int MAX_T = (RST_HOLD > MAX_A) ? RST_HOLD : MAX_A;
  localparam int CNT_W = $clog2(MAX_T + 1);

  // Terminal counts: the counter starts at 0 in the first cycle of a phase,
  // so the last allowed cycle is at limit-1.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, HOLD, WAIT_ENTRY, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, WAIT_LOCK
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_mask;
  logic [15:0]      r_data;
  logic             r_last;
  logic             r_cfg_ready;
  logic             r_pll_rst;
  logic             r_den;
  logic             r_dwe;
  logic [6:0]       r_daddr;
  logic [15:0]      r_di;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [15:0]      w_merged;

  // Keep the register bits selected by the mask and take the rest from the
  // new data.
  function automatic logic [15:0] f_merge(input logic [15:0] cur,
                                          input logic [15:0] mask,
                                          input logic [15:0] data);
    return (cur & mask) | (data & ~mask);
  endfunction

  // Merge with DO as it arrives, so DI is ready when the write strobe goes out.
  assign w_merged = f_merge(i_do, r_mask, r_data);

  always_ff @(posedge i_dclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_pll_rst   <= 1'b0;
      r_den       <= 1'b0;
      r_dwe       <= 1'b0;
      r_daddr     <= '0;
      r_di        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // Strobes last one cycle unless a transition below re-asserts them.
      r_den  <= 1'b0;
      r_dwe  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state   <= HOLD;
            r_pll_rst <= 1'b1;
            r_error   <= 1'b0;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
          end
        end
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state     <= WAIT_ENTRY;
            r_cfg_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_ENTRY: begin
          if (i_cfg_valid) begin
            r_state     <= RD_REQ;
            r_cfg_ready <= 1'b0;
            r_mask      <= i_cfg_mask;
            r_data      <= i_cfg_data;
            r_last      <= i_cfg_last;
            r_daddr     <= i_cfg_addr;
            r_den       <= 1'b1;
          end
        end
        RD_REQ: begin
          // DRDY in the enable cycle is not a response to this access.
          r_state <= RD_WAIT;
          r_cnt   <= '0;
        end
        RD_WAIT: begin
          // DRDY is checked first, so it wins over the timeout.
          if (i_drdy) begin
            r_state <= WR_REQ;
            r_di    <= w_merged;
            r_den   <= 1'b1;
            r_dwe   <= 1'b1;
          end else if (r_cnt == DRDY_LAST) begin
            // Configuration is undefined; keep the PLL in reset.
            r_state <= IDLE;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WR_REQ: begin
          r_state <= WR_WAIT;
          r_cnt   <= '0;
        end
        WR_WAIT: begin
          if (i_drdy) begin
            r_cnt <= '0;
            if (r_last) begin
              r_state   <= WAIT_LOCK;
              r_pll_rst <= 1'b0;
            end else begin
              r_state     <= WAIT_ENTRY;
              r_cfg_ready <= 1'b1;
            end
          end else if (r_cnt == DRDY_LAST) begin
            r_state <= IDLE;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (i_locked) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_cnt == LOCK_LAST) begin
            r_state <= IDLE;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cfg_ready = r_cfg_ready;
  assign o_pll_rst   = r_pll_rst;
  assign o_den       = r_den;
  assign o_dwe       = r_dwe;
  assign o_daddr     = r_daddr;
  assign o_di        = r_di;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule
